varredura_display: RTL and testbench

VARREDURA_DISPLAY -- requirements
Module: varredura_display

---
 rtl/varredura_display.sv | 137 +++++++++++++
 tb/tb_varredura_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/varredura_display.sv
// varredura_display: multiplexed scan driver for a four-digit 7-segment display.
// A prescaler sets how long each digit stays lit. The scan steps through digits
// 0..3, and a valid/ready handshake loads new values. A loaded value only
// reaches the display at a frame boundary, so one frame never mixes two values.
// Optional build macro: VARREDURA_ZERO_BLANK_EN turns on leading-zero blanking.
module varredura_display #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] valor,
    input  logic        carga,
    output logic        aceito,
    input  logic        habilita,
    output logic [3:0]  digito,
    output logic [3:0]  anodo
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } scan_t;

    logic [CW-1:0] contador;
    logic          tick;
    scan_t         estado;
    scan_t         proximo;
    logic          fronteira;
    logic          aceita;
    logic [15:0]   exibido;
    logic [15:0]   pendente;
    logic          pendente_valido;
    logic [3:0]    nibble;
    logic [3:0]    selecao;

    assign tick      = (contador == ULTIMO);
    assign fronteira = tick && (estado == D3);
    assign aceita    = carga && !pendente_valido;
    assign aceito    = ~pendente_valido;

    // Free-running prescaler; it wraps on the tick that advances the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador <= '0;
        end else if (tick) begin
            contador <= '0;
        end else begin
            contador <= contador + CW'(1);
        end
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= D0;
        end else begin
            estado <= proximo;
        end
    end

    // Next scan state: advance one digit per tick and wrap from D3 to D0.
    always_comb begin
        proximo = estado;
        if (tick) begin
            case (estado)
                D0:      proximo = D1;
                D1:      proximo = D2;
                D2:      proximo = D3;
                default: proximo = D0;
            endcase
        end
    end

    // One-entry load buffer. A new value moves to the display only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exibido         <= 16'h0000;
            pendente        <= 16'h0000;
            pendente_valido <= 1'b0;
        end else if (fronteira && pendente_valido) begin
            exibido         <= pendente;
            pendente_valido <= 1'b0;
        end else if (aceita) begin
            pendente        <= valor;
            pendente_valido <= 1'b1;
        end
    end

    // Pick the nibble and the active-low digit select for the current scan slot.
    always_comb begin
        nibble  = exibido[3:0];
        selecao = 4'b1110;
        case (estado)
            D0: begin
                nibble  = exibido[3:0];
                selecao = 4'b1110;
            end
            D1: begin
                nibble  = exibido[7:4];
                selecao = 4'b1101;
            end
            D2: begin
                nibble  = exibido[11:8];
                selecao = 4'b1011;
            end
            default: begin
                nibble  = exibido[15:12];
                selecao = 4'b0111;
            end
        endcase
`ifdef VARREDURA_ZERO_BLANK_EN
        case (estado)
            D1:      if (exibido[15:4] == 12'h000) selecao = 4'b1111;
            D2:      if (exibido[15:8] == 8'h00) selecao = 4'b1111;
            D3:      if (exibido[15:12] == 4'h0) selecao = 4'b1111;
            default: ;
        endcase
`endif
    end

    // Registered display outputs. The disable input blanks the anodes but does not affect digito.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digito <= 4'h0;
            anodo  <= 4'b1111;
        end else begin
            digito <= nibble;
            anodo  <= habilita ? selecao : 4'b1111;
        end
    end

endmodule

// File: tb/tb_varredura_display.sv
// Testbench for varredura_display with PRESCALE=4.
// The reference model works from edge counts since reset. The scan slot is
// (edges / PRESCALE) % 4. A value accepted on edge e appears on the display
// at the next multiple of 4*PRESCALE that is strictly greater than e.
module tb_varredura_display;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] valor = 16'h0000;
    logic        carga = 1'b0;
    logic        aceito;
    logic        habilita = 1'b1;
    logic [3:0]  digito;
    logic [3:0]  anodo;

    int checks = 0;
    int errors = 0;

    int          m_e = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pdata = 16'h0000;
    logic        m_pend = 1'b0;
    int          m_due = 0;
    logic [3:0]  exp_digito = 4'h0;
    logic [3:0]  exp_anodo = 4'b1111;
    logic        exp_aceito = 1'b1;

    varredura_display #(.PRESCALE(P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valor    (valor),
        .carga    (carga),
        .aceito   (aceito),
        .habilita (habilita),
        .digito   (digito),
        .anodo    (anodo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic [15:0] v, input logic h, input int n);
        carga    = c;
        valor    = v;
        habilita = h;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: the slot comes from edge arithmetic, and loads are scheduled to a due edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e        = 0;
            m_disp     = 16'h0000;
            m_pdata    = 16'h0000;
            m_pend     = 1'b0;
            m_due      = 0;
            exp_digito = 4'h0;
            exp_anodo  = 4'b1111;
            exp_aceito = 1'b1;
        end else begin
            int   slot;
            logic lit;
            logic acc;
            slot       = (m_e / P) % 4;
            exp_digito = 4'((m_disp >> (4 * slot)) & 16'h000F);
            lit        = habilita;
`ifdef VARREDURA_ZERO_BLANK_EN
            if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0000) lit = 1'b0;
`endif
            exp_anodo = lit ? ~(4'b0001 << slot) : 4'b1111;
            m_e++;
            acc = carga && !m_pend;
            if (m_pend && m_e == m_due) begin
                m_disp = m_pdata;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_pdata = valor;
                m_pend  = 1'b1;
                m_due   = ((m_e / (4 * P)) + 1) * (4 * P);
            end
            exp_aceito = !m_pend;
        end
    end

    // Compare the DUT outputs against the model on every falling clock edge.
    always @(negedge clk) begin
        checkOutput("model_digito", {12'h000, digito}, {12'h000, exp_digito});
        checkOutput("model_anodo", {12'h000, anodo}, {12'h000, exp_anodo});
        checkOutput("model_aceito", {15'h0000, aceito}, {15'h0000, exp_aceito});
    end

`ifdef VARREDURA_ZERO_BLANK_EN
    localparam logic BL = 1'b1;
`else
    localparam logic BL = 1'b0;
`endif

    // Directed scenarios with hand-computed expectations; comments track the edge count.
    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_anodo", {12'h000, anodo}, 16'h000F);
        checkOutput("reset_digito", {12'h000, digito}, 16'h0000);
        checkOutput("reset_aceito", {15'h0000, aceito}, 16'h0001);
        rst_n = 1'b1;

        applyStimulus(1'b0, 16'h0000, 1'b1, 1);
        checkOutput("e1_anodo", {12'h000, anodo}, 16'h000E);
        checkOutput("e1_digito", {12'h000, digito}, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b1, 4);
        checkOutput("e5_anodo", {12'h000, anodo}, BL ? 16'h000F : 16'h000D);
        applyStimulus(1'b0, 16'h0000, 1'b1, 4);
        checkOutput("e9_anodo", {12'h000, anodo}, BL ? 16'h000F : 16'h000B);
        applyStimulus(1'b0, 16'h0000, 1'b1, 4);
        checkOutput("e13_anodo", {12'h000, anodo}, BL ? 16'h000F : 16'h0007);
        applyStimulus(1'b0, 16'h0000, 1'b1, 4);
        checkOutput("e17_anodo", {12'h000, anodo}, 16'h000E);

        applyStimulus(1'b1, 16'h12AB, 1'b1, 1);
        checkOutput("load_aceito_low", {15'h0000, aceito}, 16'h0000);
        applyStimulus(1'b0, 16'h12AB, 1'b1, 13);
        checkOutput("e31_aceito", {15'h0000, aceito}, 16'h0000);
        applyStimulus(1'b0, 16'h12AB, 1'b1, 1);
        checkOutput("e32_aceito", {15'h0000, aceito}, 16'h0001);
        checkOutput("e32_digito_old", {12'h000, digito}, 16'h0000);
        applyStimulus(1'b0, 16'h12AB, 1'b1, 1);
        checkOutput("e33_digito", {12'h000, digito}, 16'h000B);
        checkOutput("e33_anodo", {12'h000, anodo}, 16'h000E);
        applyStimulus(1'b0, 16'h12AB, 1'b1, 4);
        checkOutput("e37_digito", {12'h000, digito}, 16'h000A);
        checkOutput("e37_anodo", {12'h000, anodo}, 16'h000D);
        applyStimulus(1'b0, 16'h12AB, 1'b1, 4);
        checkOutput("e41_digito", {12'h000, digito}, 16'h0002);
        checkOutput("e41_anodo", {12'h000, anodo}, 16'h000B);
        applyStimulus(1'b0, 16'h12AB, 1'b1, 4);
        checkOutput("e45_digito", {12'h000, digito}, 16'h0001);
        checkOutput("e45_anodo", {12'h000, anodo}, 16'h0007);

        applyStimulus(1'b1, 16'h1111, 1'b1, 1);
        applyStimulus(1'b1, 16'h2222, 1'b1, 3);
        checkOutput("b2b_aceito", {15'h0000, aceito}, 16'h0000);
        checkOutput("b2b_first", {12'h000, digito}, 16'h0001);
        applyStimulus(1'b0, 16'h2222, 1'b1, 16);
        checkOutput("b2b_second", {12'h000, digito}, 16'h0002);
        checkOutput("b2b_anodo", {12'h000, anodo}, 16'h000E);

        applyStimulus(1'b0, 16'h2222, 1'b1, 8);
        applyStimulus(1'b0, 16'h2222, 1'b0, 1);
        checkOutput("dis_anodo", {12'h000, anodo}, 16'h000F);
        checkOutput("dis_digito", {12'h000, digito}, 16'h0002);
        applyStimulus(1'b0, 16'h2222, 1'b0, 6);
        applyStimulus(1'b0, 16'h2222, 1'b1, 1);
        checkOutput("ena_phase", {12'h000, anodo}, 16'h000E);

        applyStimulus(1'b1, 16'h0005, 1'b1, 1);
        applyStimulus(1'b0, 16'h0005, 1'b1, 15);
        checkOutput("z5_d0", {8'h00, anodo, digito}, 16'h00E5);
        applyStimulus(1'b0, 16'h0005, 1'b1, 4);
        checkOutput("z5_d1", {12'h000, anodo}, BL ? 16'h000F : 16'h000D);
        applyStimulus(1'b1, 16'h0105, 1'b1, 1);
        applyStimulus(1'b0, 16'h0105, 1'b1, 11);
        checkOutput("z105_d0", {8'h00, anodo, digito}, 16'h00E5);
        applyStimulus(1'b0, 16'h0105, 1'b1, 4);
        checkOutput("z105_d1", {8'h00, anodo, digito}, 16'h00D0);
        applyStimulus(1'b0, 16'h0105, 1'b1, 4);
        checkOutput("z105_d2", {8'h00, anodo, digito}, 16'h00B1);
        applyStimulus(1'b0, 16'h0105, 1'b1, 4);
        checkOutput("z105_d3", {12'h000, anodo}, BL ? 16'h000F : 16'h0007);

        applyStimulus(1'b0, 16'h0105, 1'b1, 4);
        applyStimulus(1'b1, 16'hABCD, 1'b1, 1);
        checkOutput("pend_aceito", {15'h0000, aceito}, 16'h0000);
        applyStimulus(1'b0, 16'hABCD, 1'b1, 7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_anodo", {12'h000, anodo}, 16'h000F);
        checkOutput("async_digito", {12'h000, digito}, 16'h0000);
        checkOutput("async_aceito", {15'h0000, aceito}, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1);
        checkOutput("rst_e1", {8'h00, anodo, digito}, 16'h00E0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 32);
        checkOutput("rst_e33", {8'h00, anodo, digito}, 16'h00E0);
        checkOutput("rst_e33_aceito", {15'h0000, aceito}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
